// File: rtl/fpadd_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fpadd_stream_ctrl
// Purpose  : Credit-based valid/ready wrapper around an external FPAddSub
//            pipeline, with an in-order result FIFO.
// Option   : FPADD_STICKY_FLAGS_EN adds sticky_clr / sticky_flags.
// Revision : 1.0 - initial release
// ============================================================================
module fpadd_stream_ctrl #(
  parameter int LATENCY    = 9,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_op,
  output logic [15:0] fa_a,
  output logic [15:0] fa_b,
  output logic        fa_op,
  input  logic [15:0] fa_result,
  input  logic [4:0]  fa_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [4:0]  out_flags,
`ifdef FPADD_STICKY_FLAGS_EN
  input  logic        sticky_clr,
  output logic [4:0]  sticky_flags,
`endif
  output logic        busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic             accept, push, pop;
  logic [LATENCY:0] tok_q, tok_d;
  logic [15:0]      fa_a_q, fa_a_d, fa_b_q, fa_b_d;
  logic             fa_op_q, fa_op_d;
  logic [CNT_W-1:0] credits_q, credits_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [20:0]      mem_q [FIFO_DEPTH];
  logic [20:0]      head;

  always_comb begin
    accept    = in_valid && in_ready;
    push      = tok_q[LATENCY];
    pop       = out_valid && out_ready;
    tok_d     = {tok_q[LATENCY-1:0], accept};
    fa_a_d    = accept ? in_a  : fa_a_q;
    fa_b_d    = accept ? in_b  : fa_b_q;
    fa_op_d   = accept ? in_op : fa_op_q;

    credits_d = credits_q;
    if (accept && !pop)
      credits_d = credits_q - CNT_ONE;
    else if (!accept && pop)
      credits_d = credits_q + CNT_ONE;

    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CNT_ONE;
    else if (!push && pop)
      count_d = count_q - CNT_ONE;

    // Explicit wrap keeps non-power-of-two depths legal.
    wr_ptr_d = wr_ptr_q;
    if (push)
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    rd_ptr_d = rd_ptr_q;
    if (pop)
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tok_q     <= '0;
      fa_a_q    <= '0;
      fa_b_q    <= '0;
      fa_op_q   <= 1'b0;
      credits_q <= DEPTH_CNT;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      tok_q     <= tok_d;
      fa_a_q    <= fa_a_d;
      fa_b_q    <= fa_b_d;
      fa_op_q   <= fa_op_d;
      credits_q <= credits_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem_q[wr_ptr_q] <= {fa_flags, fa_result};
  end

  // Storage is never cleared, so the head is masked while the FIFO is empty.
  assign head       = mem_q[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign out_result = out_valid ? head[15:0]  : 16'h0000;
  assign out_flags  = out_valid ? head[20:16] : 5'b00000;
  assign in_ready   = (credits_q != '0);
  assign busy       = (|tok_q) || out_valid;
  assign fa_a       = fa_a_q;
  assign fa_b       = fa_b_q;
  assign fa_op      = fa_op_q;

`ifdef FPADD_STICKY_FLAGS_EN
  logic [4:0] sticky_q, sticky_d;

  // Clear is applied before the OR so a coincident pop is not lost.
  always_comb begin
    sticky_d = sticky_clr ? 5'b00000 : sticky_q;
    if (pop)
      sticky_d = sticky_d | out_flags;
  end

  always_ff @(posedge clk) begin
    if (rst)
      sticky_q <= '0;
    else
      sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && count_q == DEPTH_CNT))
        else $error("result FIFO written while full");
      assert (int'($countones(tok_q)) + int'(credits_q) + int'(count_q) == FIFO_DEPTH)
        else $error("credit accounting broken");
    end
  end
`endif

endmodule
`default_nettype wire
